// File: rtl/rv_mem_pkg.sv
// Memory-access width codes and the width helpers shared by the load/store unit
// and the RAM-side logic.
package rv_mem_pkg;

    localparam int MEM_XLEN = 64;

    typedef enum logic [2:0] {
        WID_B  = 3'd0,
        WID_H  = 3'd1,
        WID_W  = 3'd2,
        WID_D  = 3'd3,
        WID_BU = 3'd4,
        WID_HU = 3'd5,
        WID_WU = 3'd6
    } wid_e;

    // Number of bytes touched by an access of the given width.
    function automatic logic [3:0] wid_rank(input logic [2:0] wid);
        case (wid)
            WID_B,  WID_BU: return 4'd1;
            WID_H,  WID_HU: return 4'd2;
            WID_W,  WID_WU: return 4'd4;
            default:        return 4'd8;
        endcase
    endfunction

    function automatic logic store_wid_ok(input logic [2:0] wid);
        return wid <= WID_D;
    endfunction

    function automatic logic [MEM_XLEN-1:0] mem_extend(input logic [MEM_XLEN-1:0] d,
                                                       input logic [2:0] wid);
        case (wid)
            WID_B:   return {{56{d[7]}},  d[7:0]};
            WID_H:   return {{48{d[15]}}, d[15:0]};
            WID_W:   return {{32{d[31]}}, d[31:0]};
            WID_BU:  return {56'd0, d[7:0]};
            WID_HU:  return {48'd0, d[15:0]};
            WID_WU:  return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_sb.sv
// Store buffer: circular FIFO of {addr, data, wid} with an address CAM that
// reports the youngest valid entry matching the lookup address.
module lsu_sb
    import rv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_SIZE   = 16,
    parameter int SB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [RAM_SIZE-1:0]   push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [2:0]            push_wid,
    input  logic                  pop,
    output logic [RAM_SIZE-1:0]   head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [2:0]            head_wid,
    output logic                  empty,
    output logic                  full,
    input  logic [RAM_SIZE-1:0]   lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data,
    output logic [2:0]            hit_wid
);

    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic [RAM_SIZE-1:0]   addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [SB_DEPTH];
    logic [2:0]            wid_q  [SB_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0]      count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(SB_DEPTH));
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_wid  = wid_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; validity is carried entirely by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            wid_q[wr_ptr]  <= push_wid;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_wid  = '0;
        idx      = rd_ptr;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count && addr_q[idx] == lookup_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
                hit_wid  = wid_q[idx];
            end
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: stores are buffered and drained in idle cycles, loads go
// straight to RAM or are forwarded from the buffer, with a registered writeback.
module lsu
    import rv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_SIZE   = 16,
    parameter int SB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_load_i,
    input  logic                  req_store_i,
    input  logic [RAM_SIZE-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [2:0]            req_wid_i,
    input  logic [4:0]            req_rd_i,
    output logic [RAM_SIZE-1:0]   ram_raddr_o,
    output logic [RAM_SIZE-1:0]   ram_waddr_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [2:0]            ram_wid_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_rd_o,
    output logic                  sb_empty_o,
    output logic                  err_o
);

    logic                  is_load, is_store, load_acc, store_acc, push, drain;
    logic                  sb_empty, sb_full, sb_hit, partial;
    logic [RAM_SIZE-1:0]   sb_head_addr;
    logic [DATA_WIDTH-1:0] sb_head_data, sb_hit_data;
    logic [2:0]            sb_head_wid, sb_hit_wid;

    assign is_load     = req_load_i & ~req_store_i;
    assign is_store    = req_store_i & ~req_load_i;
    assign partial     = sb_hit && (wid_rank(sb_hit_wid) < wid_rank(req_wid_i));
    assign req_ready_o = ~sb_full & ~(req_valid_i & is_load & partial);
    assign load_acc    = req_valid_i & req_ready_o & is_load;
    assign store_acc   = req_valid_i & req_ready_o & is_store;
    assign push        = store_acc & store_wid_ok(req_wid_i);
    assign drain       = ~load_acc & ~sb_empty;
    assign sb_empty_o  = sb_empty;

    lsu_sb #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_SIZE   (RAM_SIZE),
        .SB_DEPTH   (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (req_addr_i),
        .push_data   (req_data_i),
        .push_wid    (req_wid_i),
        .pop         (drain),
        .head_addr   (sb_head_addr),
        .head_data   (sb_head_data),
        .head_wid    (sb_head_wid),
        .empty       (sb_empty),
        .full        (sb_full),
        .lookup_addr (req_addr_i),
        .hit         (sb_hit),
        .hit_data    (sb_hit_data),
        .hit_wid     (sb_hit_wid)
    );

    // Loads invert the write address so a RAM with write-to-read bypass never
    // hands back the idle write data.
    always_comb begin
        ram_read_o  = 1'b0;
        ram_write_o = 1'b0;
        ram_raddr_o = req_addr_i;
        ram_waddr_o = sb_head_addr;
        ram_wdata_o = sb_head_data;
        ram_wid_o   = sb_head_wid;
        if (!rst) begin
            if (load_acc) begin
                ram_read_o  = 1'b1;
                ram_waddr_o = ~req_addr_i;
                ram_wid_o   = req_wid_i;
            end else if (drain) begin
                ram_write_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_data_o  <= '0;
            wb_rd_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= load_acc;
            err_o      <= store_acc & ~store_wid_ok(req_wid_i);
            if (load_acc) begin
                wb_rd_o   <= req_rd_i;
                wb_data_o <= sb_hit ? DATA_WIDTH'(mem_extend(MEM_XLEN'(sb_hit_data), req_wid_i))
                                    : ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a program-order memory model.
module tb_lsu;

    localparam int DW  = 64;
    localparam int AW  = 16;
    localparam int SBD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i, req_ready_o, req_load_i, req_store_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic [2:0]    req_wid_i;
    logic [4:0]    req_rd_i;
    logic [AW-1:0] ram_raddr_o, ram_waddr_o;
    logic          ram_read_o, ram_write_o;
    logic [DW-1:0] ram_wdata_o, ram_rdata_i;
    logic [2:0]    ram_wid_o;
    logic          wb_valid_o, sb_empty_o, err_o;
    logic [DW-1:0] wb_data_o;
    logic [4:0]    wb_rd_o;

    always #5 clk = ~clk;

    lsu #(.DATA_WIDTH(DW), .RAM_SIZE(AW), .SB_DEPTH(SBD)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_load_i(req_load_i), .req_store_i(req_store_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_wid_i(req_wid_i), .req_rd_i(req_rd_i),
        .ram_raddr_o(ram_raddr_o), .ram_waddr_o(ram_waddr_o),
        .ram_read_o(ram_read_o), .ram_write_o(ram_write_o),
        .ram_wdata_o(ram_wdata_o), .ram_wid_o(ram_wid_o),
        .ram_rdata_i(ram_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .sb_empty_o(sb_empty_o), .err_o(err_o)
    );

    typedef struct { logic [AW-1:0] a; logic [63:0] d; logic [2:0] w; } wr_t;
    typedef struct { logic [63:0] d; logic [4:0] rd; } ld_t;

    logic [63:0] mem    [256];
    logic [63:0] shadow [256];
    wr_t         wq[$];
    ld_t         lq[$];
    wr_t         we;
    ld_t         le;
    logic        err_pend = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] w);
        case (w)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic logic [63:0] ref_ext(input logic [63:0] v, input logic [2:0] w);
        int          sh;
        logic [63:0] t;
        sh = 64 - 8 * nbytes(w);
        t  = v << sh;
        if (w <= 3'd2) return $unsigned($signed(t) >>> sh);
        return t >> sh;
    endfunction

    function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] nw,
                                              input logic [2:0] w);
        logic [63:0] m;
        m = (nbytes(w) == 8) ? '1 : ((64'd1 << (8 * nbytes(w))) - 64'd1);
        return (old & ~m) | (nw & m);
    endfunction

    assign ram_rdata_i = ref_ext(mem[ram_raddr_o[7:0]], ram_wid_o);

    // Environment RAM plus write-order and writeback scoreboards.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ram_en", {62'd0, ram_read_o, ram_write_o}, 64'd0);
        end else begin
            if (ram_write_o) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", 64'(ram_waddr_o), 64'(we.a));
                    chk("wr_data", ram_wdata_o, we.d);
                    chk("wr_wid", 64'(ram_wid_o), 64'(we.w));
                end
                mem[ram_waddr_o[7:0]] = ref_merge(mem[ram_waddr_o[7:0]], ram_wdata_o, ram_wid_o);
            end
            if (wb_valid_o) begin
                if (lq.size() == 0) begin
                    chk("unexpected_wb", 1, 0);
                end else begin
                    le = lq.pop_front();
                    chk("wb_data", wb_data_o, le.d);
                    chk("wb_rd", 64'(wb_rd_o), 64'(le.rd));
                end
            end
            chk("err_pulse", 64'(err_o), 64'(err_pend));
            err_pend = 1'b0;
        end
    end

    task automatic do_req(input logic ld, input logic st, input logic [AW-1:0] a,
                          input logic [63:0] d, input logic [2:0] w, input logic [4:0] rd,
                          output int waited);
        wr_t s;
        ld_t l;
        @(negedge clk);
        req_valid_i = 1'b1; req_load_i = ld; req_store_i = st;
        req_addr_i = a; req_data_i = d; req_wid_i = w; req_rd_i = rd;
        #1;
        waited = 0;
        while (!req_ready_o && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready_o) begin
            chk("req_timeout", 0, 1);
            req_valid_i = 1'b0;
            return;
        end
        if (ld && !st) begin
            l.d = ref_ext(shadow[a[7:0]], w);
            l.rd = rd;
            lq.push_back(l);
        end else if (st && !ld) begin
            if (w <= 3'd3) begin
                s.a = a; s.d = d; s.w = w;
                wq.push_back(s);
                shadow[a[7:0]] = ref_merge(shadow[a[7:0]], d, w);
            end else begin
                err_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!sb_empty_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(sb_empty_o), 64'd1);
    endtask

    initial begin
        int          wt, r;
        logic [2:0]  w;
        logic [63:0] d;
        req_valid_i = 0; req_load_i = 0; req_store_i = 0;
        req_addr_i = '0; req_data_i = '0; req_wid_i = '0; req_rd_i = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom};
            shadow[i] = mem[i];
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(wb_valid_o), 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_rd", 64'(wb_rd_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_sb_empty", 64'(sb_empty_o), 1);
        @(negedge clk);
        rst = 1'b0;

        // Store D, drain in the idle cycle, read back from RAM.
        do_req(0, 1, 16'h10, 64'h1122334455667788, 3'd3, 5'd1, wt);
        @(posedge clk); #1;
        chk("drain_mem_d", mem[8'h10], 64'h1122334455667788);
        do_req(1, 0, 16'h10, 64'd0, 3'd3, 5'd2, wt);
        chk("ld_d_ram", wb_data_o, 64'h1122334455667788);

        // Forwarding with sign and zero extension.
        wait_empty();
        do_req(0, 1, 16'h20, 64'h0000000080000001, 3'd2, 5'd0, wt);
        do_req(1, 0, 16'h20, 64'd0, 3'd2, 5'd3, wt);
        chk("fwd_no_stall", 64'(wt), 0);
        chk("fwd_w", wb_data_o, 64'hFFFFFFFF80000001);
        do_req(1, 0, 16'h20, 64'd0, 3'd6, 5'd4, wt);
        chk("fwd_wu", wb_data_o, 64'h0000000080000001);

        // Partial hit stalls until the byte store drains.
        wait_empty();
        do_req(0, 1, 16'h30, 64'h00000000000000AB, 3'd0, 5'd0, wt);
        do_req(1, 0, 16'h30, 64'd0, 3'd3, 5'd5, wt);
        chk("partial_stall", 64'(wt), 1);
        chk("partial_lowbyte", 64'(wb_data_o[7:0]), 64'hAB);

        // Stores interleaved with loads; write order is checked by the monitor.
        for (int i = 0; i < SBD; i++) begin
            do_req(0, 1, AW'(16'h40 + i), {$urandom, $urandom}, 3'd3, 5'd0, wt);
            do_req(1, 0, 16'h50, 64'd0, 3'd3, 5'(i), wt);
        end
        wait_empty();

        // Illegal store width is dropped with an error pulse.
        do_req(0, 1, 16'h44, 64'hDEAD, 3'd4, 5'd0, wt);
        chk("bu_err", 64'(err_o), 1);
        chk("bu_empty", 64'(sb_empty_o), 1);
        repeat (3) @(posedge clk);

        // Reset with an undrained store discards it.
        do_req(0, 1, 16'h60, 64'hCAFE, 3'd3, 5'd0, wt);
        do_req(1, 0, 16'h61, 64'd0, 3'd3, 5'd6, wt);
        chk("pre_rst_full", 64'(sb_empty_o), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_empty", 64'(sb_empty_o), 1);
        chk("rst_mid_wb", 64'(wb_valid_o), 0);
        chk("rst_mid_write", 64'(ram_write_o), 0);
        wq.delete();
        lq.delete();
        err_pend = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_empty", 64'(sb_empty_o), 1);

        // Randomized traffic over a small address window to provoke hits.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            d = {$urandom, $urandom};
            if (r <= 3) begin
                w = 3'($urandom_range(0, 6));
                do_req(1, 0, AW'($urandom_range(0, 7)), d, w, 5'($urandom_range(0, 31)), wt);
            end else if (r <= 7) begin
                w = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                do_req(0, 1, AW'($urandom_range(0, 7)), d, w, 5'd0, wt);
            end else if (r == 8) begin
                do_req(1'($urandom_range(0, 1)) ? 1'b1 : 1'b0, 1'b0, 16'h3, d, 3'd3, 5'd0, wt);
            end else begin
                @(posedge clk);
            end
        end
        wait_empty();
        repeat (3) @(posedge clk);
        #1;
        chk("final_wq", 64'(wq.size()), 0);
        chk("final_lq", 64'(lq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
